// File: rtl/pwm_generator.sv
// Free-running single-channel PWM: a WIDTH-bit counter sets a 2^WIDTH-clock period,
// and a registered unsigned compare against duty_cycle sets the high time.
module pwm_generator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_cycle,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             pwm_q;
    logic             pwm_d;

    // Compare uses the pre-increment count, so the output lags the counter by one clock.
    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        pwm_d = (cnt_q < duty_cycle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: directed scenarios plus randomized duty
// values, checked against a period-arithmetic reference model.
module tb_pwm_generator;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PERIOD = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] duty_cycle = '0;
    logic             pwm_out;

    int n_assert = 0;
    int n_fail   = 0;
    int edges    = 0;   // rising edges seen since the last reset release

    pwm_generator #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .duty_cycle (duty_cycle),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: the model's counter position is simply edges mod PERIOD.
    task automatic tick(input string tag);
        logic exp;
        @(posedge clk);
        if (!rst) begin
            exp = 1'b0;
        end else begin
            exp = ((edges % PERIOD) < 32'(duty_cycle));
            edges++;
        end
        #1;
        check(tag, 32'(pwm_out), 32'(exp));
    endtask

    // Must start aligned to a period boundary; checks the total high time.
    task automatic run_period(input string tag, input int exp_high);
        int h;
        h = 0;
        repeat (PERIOD) begin
            tick(tag);
            if (pwm_out === 1'b1) h++;
        end
        check({tag, "_high"}, 32'(h), 32'(exp_high));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_async"}, 32'(pwm_out), 32'd0);
        edges = 0;
        tick({tag, "_hold"});
        tick({tag, "_hold"});
        rst = 1'b1;
    endtask

    initial begin
        int d;

        // 1: reset with duty 0, then a full period of constant low
        #1;
        do_reset("t1_rst");
        run_period("t1", 0);

        // 2: duty 64 from reset release
        duty_cycle = 8'd64;
        do_reset("t2_rst");
        run_period("t2", 64);
        run_period("t2", 64);

        // 3: stepped duty, two periods each
        duty_cycle = 8'd128;
        run_period("t3_128", 128);
        run_period("t3_128", 128);
        duty_cycle = 8'd192;
        run_period("t3_192", 192);
        run_period("t3_192", 192);
        duty_cycle = 8'd32;
        run_period("t3_32", 32);
        run_period("t3_32", 32);

        // 4: near-full duty, single low clock after the cnt==255 edge
        duty_cycle = 8'd255;
        run_period("t4", 255);
        check("t4_last_low", 32'(pwm_out), 32'd0);
        run_period("t4", 255);

        // 5: raise duty mid-period while output is low
        duty_cycle = 8'd64;
        do_reset("t5_rst");
        repeat (100) tick("t5");
        check("t5_low_at_100", 32'(pwm_out), 32'd0);
        duty_cycle = 8'd128;
        tick("t5");
        check("t5_rise", 32'(pwm_out), 32'd1);
        while (edges < 128) tick("t5");
        check("t5_high_before_128", 32'(pwm_out), 32'd1);
        tick("t5");
        check("t5_fall", 32'(pwm_out), 32'd0);
        while (edges < PERIOD) tick("t5");

        // 6: reset mid-period, then a clean 128-clock pulse
        duty_cycle = 8'd128;
        repeat (50) tick("t6_pre");
        do_reset("t6_rst");
        tick("t6_first");
        check("t6_first_high", 32'(pwm_out), 32'd1);
        repeat (PERIOD - 1) tick("t6");

        // Randomized whole-period duty values
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, PERIOD - 1));
            duty_cycle = WIDTH'(d);
            run_period("rnd_period", d);
        end

        // Randomized mid-period duty changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) duty_cycle = WIDTH'($urandom);
            tick("rnd_change");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
